dmem_arbiter: RTL and testbench

Two-port arbiter and access sequencer in front of the single-port data memory. It shares the memory between the processor's control unit (port 0) and a loader/debug port (port 1). It arbitrates round-robin and drives the memory's addr/rd/wr/W_data strobes from registers for exactly one cycle per access. It returns read data with a one-cycle ack pulse to the winning requester.

---
 rtl/dmem_arbiter.sv | 113 +++++++++++
 tb/tb_dmem_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between two requesters.
// Each granted access takes three cycles: arbitrate, strobe the memory, acknowledge.
module dmem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          ack0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          ack1,
    output logic [DW-1:0] rdata1,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    output logic          mem_wr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] RESP   = 2'd2;

    logic [1:0]    state;
    logic          last_grant;
    logic          sel;
    logic          we_l;

    logic          grant1;
    logic          g_we;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata;

    // A tie goes to whichever port was not served last.
    always_comb begin
        grant1  = req1 && (!req0 || !last_grant);
        g_we    = grant1 ? we1    : we0;
        g_addr  = grant1 ? addr1  : addr0;
        g_wdata = grant1 ? wdata1 : wdata0;
    end

    // The strobes come straight from flops so the level-sensitive write never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            sel        <= 1'b0;
            we_l       <= 1'b0;
            ack0       <= 1'b0;
            ack1       <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            mem_wr     <= 1'b0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        sel       <= grant1;
                        we_l      <= g_we;
                        mem_addr  <= g_addr;
                        mem_rd    <= !g_we;
                        mem_wr    <= g_we;
                        mem_wdata <= g_we ? g_wdata : '0;
                        busy      <= 1'b1;
                        state     <= ACCESS;
                    end
                end
                ACCESS: begin
                    mem_rd    <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_wdata <= '0;
                    if (!we_l) begin
                        if (sel) rdata1 <= mem_rdata;
                        else     rdata0 <= mem_rdata;
                    end
                    ack0      <= !sel;
                    ack1      <= sel;
                    state     <= RESP;
                end
                RESP: begin
                    ack0       <= 1'b0;
                    ack1       <= 1'b0;
                    last_grant <= sel;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    mem_rd    <= 1'b0;
                    mem_wr    <= 1'b0;
                    mem_wdata <= '0;
                    ack0      <= 1'b0;
                    ack1      <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: behavioural memory plus a transaction-timeline model
// predicting grants, strobes, acks and read data cycle by cycle.
module tb_dmem_arbiter;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          ack0, ack1, mem_rd, mem_wr, busy;
    logic [DW-1:0] rdata0, rdata1, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory: asynchronous read, writes while wr is high at the rising edge.
    logic [DW-1:0] mem [256];
    assign mem_rdata = mem[mem_addr];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= 16'(3 * (i + 1) * (i + 1));
        forever begin
            @(posedge clk);
            if (mem_wr === 1'b1) mem[mem_addr] <= mem_wdata;
        end
    end

    typedef struct {
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } req_t;

    int            compared = 0;
    int            mismatched = 0;
    int            k = 0;
    int            g = -100;
    int            next_free = 0;
    bit            gsel, gwe, lastg, gaps;
    logic [AW-1:0] gaddr, exp_addr;
    logic [DW-1:0] gwdata, gexp;
    logic [DW-1:0] ref_mem [256];
    logic [DW-1:0] exp_rdata [2];
    req_t          q0[$], q1[$];
    req_t          cur [2];
    bit            pend [2];
    int            ack_log[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic reset_model();
        g = -100;
        next_free = k;
        lastg = 1'b1;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        exp_addr = '0;
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic drive_inputs();
        req0 = pend[0]; we0 = cur[0].we; addr0 = cur[0].addr; wdata0 = cur[0].wdata;
        req1 = pend[1]; we1 = cur[1].we; addr1 = cur[1].addr; wdata1 = cur[1].wdata;
    endtask

    // Decide this cycle's requests, and the grant when the arbiter is free.
    task automatic plan_cycle();
        if (!pend[0] && q0.size() > 0 && (!gaps || $urandom_range(2) != 0)) begin
            cur[0] = q0.pop_front();
            pend[0] = 1'b1;
        end
        if (!pend[1] && q1.size() > 0 && (!gaps || $urandom_range(2) != 0)) begin
            cur[1] = q1.pop_front();
            pend[1] = 1'b1;
        end
        drive_inputs();
        if (k >= next_free && (pend[0] || pend[1])) begin
            if (pend[0] && pend[1]) gsel = !lastg;
            else                    gsel = pend[1];
            lastg  = gsel;
            g      = k;
            next_free = k + 3;
            gwe    = cur[gsel].we;
            gaddr  = cur[gsel].addr;
            gwdata = cur[gsel].wdata;
            if (gwe) ref_mem[gaddr] = gwdata;
            else     gexp = ref_mem[gaddr];
        end
    endtask

    task automatic advance_and_check();
        @(posedge clk);
        #1;
        k++;
        if (k == g + 1) exp_addr = gaddr;
        if (k == g + 2 && !gwe) exp_rdata[gsel] = gexp;
        chk("mem_rd", mem_rd, (k == g + 1) && !gwe);
        chk("mem_wr", mem_wr, (k == g + 1) && gwe);
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_wdata", mem_wdata, (k == g + 1 && gwe) ? gwdata : 16'h0);
        chk("ack0", ack0, (k == g + 2) && !gsel);
        chk("ack1", ack1, (k == g + 2) && gsel);
        chk("rdata0", rdata0, exp_rdata[0]);
        chk("rdata1", rdata1, exp_rdata[1]);
        chk("busy", busy, (k == g + 1) || (k == g + 2));
        if (ack0 === 1'b1) ack_log.push_back(0);
        if (ack1 === 1'b1) ack_log.push_back(1);
        if (k == g + 2) pend[gsel] = 1'b0;
    endtask

    task automatic step();
        advance_and_check();
        plan_cycle();
    endtask

    task automatic drain(input int budget);
        int  n = 0;
        bit  done;
        while ((pend[0] || pend[1] || q0.size() > 0 || q1.size() > 0 || k < next_free) && n < budget) begin
            step();
            n++;
        end
        done = !(pend[0] || pend[1] || q0.size() > 0 || q1.size() > 0 || k < next_free);
        chk("drain_done", done, 1);
    endtask

    task automatic do_reset(input int ncyc);
        rst = 1'b1;
        req0 = 1'b1;
        req1 = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            k++;
            chk("rst_mem_rd", mem_rd, 0);
            chk("rst_mem_wr", mem_wr, 0);
            chk("rst_mem_addr", mem_addr, 0);
            chk("rst_mem_wdata", mem_wdata, 0);
            chk("rst_ack0", ack0, 0);
            chk("rst_ack1", ack1, 0);
            chk("rst_rdata0", rdata0, 0);
            chk("rst_rdata1", rdata1, 0);
            chk("rst_busy", busy, 0);
        end
        rst = 1'b0;
        reset_model();
    endtask

    initial begin
        req_t r;
        int   first;
        for (int i = 0; i < 256; i++) ref_mem[i] = 16'(3 * (i + 1) * (i + 1));
        cur[0] = '{1'b0, '0, '0};
        cur[1] = '{1'b0, '0, '0};
        gaps = 1'b0;

        // Reset with both requests high, then a tie: port 0 must win first.
        do_reset(2);
        q0.push_back('{1'b0, 8'h00, 16'h0});
        q1.push_back('{1'b0, 8'h01, 16'h0});
        ack_log.delete();
        plan_cycle();
        drain(40);
        chk("tie_ack_count", ack_log.size(), 2);
        chk("tie_first_port", ack_log[0], 0);
        chk("tie_second_port", ack_log[1], 1);

        // Single reads from port 0.
        q0.push_back('{1'b0, 8'h00, 16'h0});
        plan_cycle();
        drain(20);
        chk("read_addr0", rdata0, 16'h0003);
        q0.push_back('{1'b0, 8'h01, 16'h0});
        plan_cycle();
        drain(20);
        chk("read_addr1", rdata0, 16'h000C);

        // Port 1 writes, port 0 reads it back.
        q1.push_back('{1'b1, 8'h05, 16'hABCD});
        plan_cycle();
        drain(20);
        chk("write_keeps_rdata1", rdata1, 16'h000C);
        q0.push_back('{1'b0, 8'h05, 16'h0});
        plan_cycle();
        drain(20);
        chk("read_back_05", rdata0, 16'hABCD);

        // Continuous contention: 12 accesses must alternate.
        ack_log.delete();
        first = lastg ? 0 : 1;
        for (int i = 0; i < 6; i++) begin
            r = '{bit'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom)};
            q0.push_back(r);
            r = '{bit'($urandom_range(1)), 8'($urandom_range(15)), 16'($urandom)};
            q1.push_back(r);
        end
        plan_cycle();
        drain(100);
        chk("contention_count", ack_log.size(), 12);
        for (int i = 0; i < ack_log.size(); i++) chk("alternation", ack_log[i], first ^ (i % 2));

        // Random traffic with idle gaps on a small address range.
        gaps = 1'b1;
        for (int i = 0; i < 20; i++) begin
            r = '{bit'($urandom_range(1)), 8'($urandom_range(7)), 16'($urandom)};
            q0.push_back(r);
            r = '{bit'($urandom_range(1)), 8'($urandom_range(7)), 16'($urandom)};
            q1.push_back(r);
        end
        plan_cycle();
        drain(600);
        gaps = 1'b0;

        // Reset while port 1's write strobe is on the bus.
        ack_log.delete();
        q1.push_back('{1'b1, 8'h22, 16'h5A5A});
        plan_cycle();
        for (int i = 0; i < 10 && k != g + 1; i++) step();
        chk("abort_strobe_reached", k, g + 1);
        do_reset(1);
        chk("abort_no_ack", ack_log.size(), 0);
        q1.push_back('{1'b0, 8'h22, 16'h0});
        plan_cycle();
        drain(20);
        chk("post_reset_ack_count", ack_log.size(), 1);
        chk("post_reset_read", rdata1, 16'h5A5A);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
